// File: rtl/comm_hub.sv
// Nibble-serial host hub: command decode, per-channel config and tx/rx words.
// One host transaction at a time; channel tx handshakes run independently.
module comm_hub #(
    parameter int N_CH   = 3,
    parameter int DATA_W = 16,
    parameter int CFG_W  = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [3:0]               data_in,
    input  logic                     data_en,
    output logic [3:0]               data_out,
    output logic [3:0]               data_op_en,
    output logic [N_CH*CFG_W-1:0]    ch_cfg,
    output logic [N_CH*DATA_W-1:0]   ch_tx_data,
    output logic [N_CH-1:0]          ch_tx_valid,
    input  logic [N_CH-1:0]          ch_tx_ready,
    input  logic [N_CH*DATA_W-1:0]   ch_rx_data,
    input  logic [N_CH-1:0]          ch_rx_valid,
    output logic [N_CH-1:0]          ch_rx_ack,
    input  logic [N_CH-1:0]          ch_busy,
    output logic                     cmd_error,
    output logic                     irq
);
    localparam int NIB  = DATA_W / 4;
    localparam int CNIB = CFG_W / 4;
    localparam int MAXN = (NIB > CNIB) ? NIB : CNIB;
    localparam int CW   = $clog2(MAXN + 1);
    localparam int SW   = (DATA_W > CFG_W) ? DATA_W : CFG_W;

    typedef enum logic [2:0] {IDLE, RD, ST, WR_CFG, WR_DATA} state_t;

    state_t                 st_q, st_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             ch_q, ch_d;
    logic [SW-1:0]          sh_q, sh_d, sh_nx;
    logic [DATA_W-1:0]      rdw_q, rdw_d, rd_w, rxd_s;
    logic                   rdok_q, rdok_d, drop_q, drop_d;
    logic [3:0]             dout_q, dout_d, doe_q, doe_d;
    logic [N_CH*CFG_W-1:0]  cfg_q, cfg_d;
    logic [N_CH*DATA_W-1:0] txd_q, txd_d;
    logic [N_CH-1:0]        txv_q, txv_d, ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   ch_ok, rxv_s, txv_s, bsy_s;

    assign data_out    = dout_q;
    assign data_op_en  = doe_q;
    assign ch_cfg      = cfg_q;
    assign ch_tx_data  = txd_q;
    assign ch_tx_valid = txv_q;
    assign ch_rx_ack   = ack_q;
    assign cmd_error   = err_q;
    assign irq         = (|ch_rx_valid) | err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            ch_q   <= '0;
            sh_q   <= '0;
            rdw_q  <= '0;
            rdok_q <= 1'b0;
            drop_q <= 1'b0;
            dout_q <= '0;
            doe_q  <= '0;
            cfg_q  <= '0;
            txd_q  <= '0;
            txv_q  <= '0;
            ack_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            ch_q   <= ch_d;
            sh_q   <= sh_d;
            rdw_q  <= rdw_d;
            rdok_q <= rdok_d;
            drop_q <= drop_d;
            dout_q <= dout_d;
            doe_q  <= doe_d;
            cfg_q  <= cfg_d;
            txd_q  <= txd_d;
            txv_q  <= txv_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        ch_d   = ch_q;
        sh_d   = sh_q;
        rdw_d  = rdw_q;
        rdok_d = rdok_q;
        drop_d = drop_q;
        dout_d = dout_q;
        doe_d  = doe_q;
        cfg_d  = cfg_q;
        txd_d  = txd_q;
        ack_d  = '0;
        err_d  = err_q;
        // a load below overrides the ready-driven clear
        txv_d  = txv_q & ~ch_tx_ready;
        sh_nx  = (sh_q << 4) | SW'(data_in);

        ch_ok = 1'b0;
        rxv_s = 1'b0;
        txv_s = 1'b0;
        bsy_s = 1'b0;
        rxd_s = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (data_in[1:0] == 2'(k)) begin
                ch_ok = 1'b1;
                rxv_s = ch_rx_valid[k];
                txv_s = txv_q[k];
                bsy_s = ch_busy[k];
                rxd_s = ch_rx_data[k*DATA_W +: DATA_W];
            end
        end
        rd_w = rxv_s ? rxd_s : '0;

        unique case (st_q)
            IDLE: begin
                if (data_en && !ch_ok) begin
                    err_d = 1'b1;
                end else if (data_en) begin
                    ch_d  = data_in[1:0];
                    cnt_d = '0;
                    sh_d  = '0;
                    unique case (data_in[3:2])
                        2'b00: begin
                            st_d   = RD;
                            doe_d  = 4'hF;
                            rdok_d = rxv_s;
                            err_d  = err_q | ~rxv_s;
                            dout_d = rd_w[DATA_W-1 -: 4];
                            rdw_d  = rd_w << 4;
                            cnt_d  = CW'(NIB - 1);
                        end
                        2'b01: begin
                            st_d   = ST;
                            doe_d  = 4'hF;
                            dout_d = {rxv_s, txv_s, bsy_s, err_q};
                        end
                        2'b10: begin
                            st_d   = WR_DATA;
                            drop_d = txv_s;
                            err_d  = err_q | txv_s;
                        end
                        2'b11: st_d = WR_CFG;
                    endcase
                end
            end
            RD: begin
                if (cnt_q != '0) begin
                    dout_d = rdw_q[DATA_W-1 -: 4];
                    rdw_d  = rdw_q << 4;
                    cnt_d  = cnt_q - 1'b1;
                end else begin
                    doe_d = '0;
                    st_d  = IDLE;
                    for (int k = 0; k < N_CH; k++)
                        if (rdok_q && ch_q == 2'(k)) ack_d[k] = 1'b1;
                end
            end
            ST: begin
                doe_d = '0;
                st_d  = IDLE;
                err_d = 1'b0;
            end
            WR_CFG: begin
                if (data_en) begin
                    sh_d  = sh_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(CNIB - 1)) begin
                        st_d  = IDLE;
                        cnt_d = '0;
                        for (int k = 0; k < N_CH; k++)
                            if (ch_q == 2'(k))
                                cfg_d[k*CFG_W +: CFG_W] = sh_nx[CFG_W-1:0];
                    end
                end
            end
            WR_DATA: begin
                if (data_en) begin
                    sh_d  = sh_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(NIB - 1)) begin
                        st_d  = IDLE;
                        cnt_d = '0;
                        for (int k = 0; k < N_CH; k++) begin
                            if (!drop_q && ch_q == 2'(k)) begin
                                txd_d[k*DATA_W +: DATA_W] = sh_nx[DATA_W-1:0];
                                txv_d[k] = 1'b1;
                            end
                        end
                    end
                end
            end
            default: st_d = IDLE;
        endcase
    end
endmodule

// File: doc/comm_hub.md
COMM_HUB -- requirements
Module: comm_hub

Interface
REQ-001 SHALL have parameter N_CH, default 3, number of peripheral channels (legal 1..4).
REQ-002 SHALL have parameter DATA_W, default 16, channel data width in bits (multiple of 4, legal 4..32); NIB = DATA_W/4.
REQ-003 SHALL have parameter CFG_W, default 12, per-channel config width in bits (multiple of 4); CNIB = CFG_W/4.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 data_in  input  4  host nibble bus, MSB-first.
REQ-007 data_en  input  1  host nibble strobe; a nibble is sampled only on edges where data_en=1.
REQ-008 data_out  output  4  host read nibble.
REQ-009 data_op_en  output  4  pad direction; 4'b1111 drives data_out, 4'b0000 is input.
REQ-010 ch_cfg  output  N_CH*CFG_W  per-channel config registers; channel k at [k*CFG_W +: CFG_W].
REQ-011 ch_tx_data  output  N_CH*DATA_W  per-channel transmit word.
REQ-012 ch_tx_valid  output  N_CH  per-channel transmit request.
REQ-013 ch_tx_ready  input  N_CH  peripheral accepts word when valid&ready.
REQ-014 ch_rx_data  input  N_CH*DATA_W  per-channel received word.
REQ-015 ch_rx_valid  input  N_CH  received word available.
REQ-016 ch_rx_ack  output  N_CH  one-cycle pulse consuming the received word.
REQ-017 ch_busy  input  N_CH  peripheral busy.
REQ-018 cmd_error  output  1  sticky error flag.
REQ-019 irq  output  1  OR over channels of ch_rx_valid, plus cmd_error; combinational.

Function
REQ-020 Command nibble {op[1:0], ch[1:0]} SHALL be accepted only in IDLE on a data_en cycle; op 00=READ, 01=STATUS, 10=WRITE_DATA, 11=WRITE_CFG.
REQ-021 ch >= N_CH SHALL set cmd_error and remain in IDLE, with no other state change.
REQ-022 States SHALL be IDLE, RD, ST, WR_CFG, WR_DATA; nibble counter width = clog2(max(NIB,CNIB)+1).
REQ-023 READ: the edge after the command SHALL set data_op_en=4'b1111 and data_out=rx word nibble NIB-1; then one nibble per clock, down to nibble 0, independent of data_en.
REQ-024 READ: on the clock after nibble 0 is presented, data_op_en SHALL return to 0 and state to IDLE; ch_rx_ack[ch] SHALL pulse for that one cycle only if ch_rx_valid[ch] was 1 at command acceptance.
REQ-025 READ with ch_rx_valid[ch]=0 at acceptance SHALL output NIB nibbles of 4'h0, issue no ack, and set cmd_error.
REQ-026 STATUS: SHALL drive a single nibble {ch_rx_valid[ch], ch_tx_valid[ch], ch_busy[ch], cmd_error} with data_op_en=1111 for one cycle; after that nibble cmd_error SHALL clear, unless a new error occurs in that same cycle.
REQ-027 WRITE_CFG: SHALL collect CNIB data_en-qualified nibbles MSB-first into a shadow register; the last nibble SHALL commit the complete word to ch_cfg[ch] on that edge, then the block SHALL return to IDLE. Cycles with data_en=0 SHALL stall without loss.
REQ-028 WRITE_DATA: SHALL collect NIB data_en-qualified nibbles into a shadow register; on the last nibble, ch_tx_data[ch] SHALL load and ch_tx_valid[ch] SHALL set on the same edge.
REQ-029 ch_tx_valid[ch] SHALL hold, with ch_tx_data[ch] stable, until an edge with ch_tx_ready[ch]=1, then clear.
REQ-030 WRITE_DATA to a channel whose ch_tx_valid is 1 at command acceptance SHALL set cmd_error and still consume NIB nibbles, which are discarded; the pending word SHALL be unchanged.
REQ-031 Channels SHALL operate independently; tx handshakes on other channels proceed during any host transaction.
REQ-032 If a word's last nibble and ready for the old word occur in the same cycle, no error SHALL occur (the pending check applies only at command acceptance); the new word SHALL load and valid SHALL remain 1.
REQ-033 data_out SHALL hold its last value when data_op_en=0.

Reset
REQ-034 reset_n=0 SHALL immediately force: state IDLE, counters 0, data_out=0, data_op_en=0, ch_cfg=0, ch_tx_data=0, ch_tx_valid=0, ch_rx_ack=0, cmd_error=0.
REQ-035 Reset mid-transaction SHALL discard partial shadow data; no config or tx commit SHALL occur.

Verification
REQ-036 WRITE_CFG ch1 with nibbles A,B,C, with data_en low 2 cycles between B and C -> ch_cfg[1]=12'hABC after C; other channels remain 0.
REQ-037 WRITE_DATA ch0 with 1,2,3,4 and ch_tx_ready low 5 cycles -> ch_tx_data[0]=16'h1234, valid held 5 cycles, cleared on the ready edge.
REQ-038 ch_rx_data[2]=16'hBEEF with valid=1, command READ ch2 -> data_out B,E,E,F on consecutive cycles with data_op_en=1111; one ack pulse; irq deasserts after valid drops.
REQ-039 Command 4'b0011 with N_CH=3 -> cmd_error=1, state IDLE; STATUS ch0 returns 4'b0001, then cmd_error=0.
REQ-040 Second WRITE_DATA ch0 while the first word is pending -> cmd_error=1, ch_tx_data[0] unchanged.
REQ-041 reset_n pulsed low after 2 of 4 WRITE_DATA nibbles -> all outputs 0 asynchronously; no valid asserted afterward.
